// File: rtl/display_mux_7seg.sv
// -----------------------------------------------------------------------------
// display_mux_7seg
//   Reads the four BCD digits of the counter, snapshots them once per frame and
//   time-multiplexes them onto a single 7-segment bus. Each digit slot starts
//   with a short dead-time with every anode off, which suppresses ghosting.
//   Leading-zero blanking is also applied.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   Qdata3..0    BCD digits (3 = thousands, 0 = units)
//   dp_mask      decimal point enable per digit (bit i = digit i)
//   lz_en        leading-zero blanking enable, sampled at snapshot
//   an           anode enables, an[0] = units (rightmost)
//   seg          segments {g,f,e,d,c,b,a}
//   dp           decimal point
//   digit_idx    digit currently selected
//   frame_tick   1-cycle pulse marking the cycle after a snapshot
// -----------------------------------------------------------------------------
module display_mux_7seg #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 16,
  parameter bit COMMON_ANODE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Qdata3,
  input  logic [3:0] Qdata2,
  input  logic [3:0] Qdata1,
  input  logic [3:0] Qdata0,
  input  logic [3:0] dp_mask,
  input  logic       lz_en,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] digit_idx,
  output logic       frame_tick
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

  // Inactive pin levels depend on the board's display polarity.
  localparam logic [3:0] AN_OFF  = COMMON_ANODE ? 4'hF : 4'h0;
  localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = COMMON_ANODE;

  typedef enum logic {SLOT_BLANK, SLOT_DRIVE} slot_state_t;

  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;  // non-BCD nibble shows '-'
    endcase
    return s;
  endfunction

  // Scan position
  logic [CNT_W-1:0] cnt_reg;
  logic [1:0]       scan_idx_reg;

  // Frame snapshot
  logic [3:0][3:0] shadow_reg;
  logic [3:0]      dp_shadow_reg;
  logic            lz_shadow_reg;

  // Registered pins
  logic [3:0] an_reg,   an_next;
  logic [6:0] seg_reg,  seg_next;
  logic       dp_reg,   dp_next;
  logic [1:0] digit_idx_reg;
  logic       frame_tick_reg;

  logic        snapshot;
  slot_state_t slot_state;

  assign snapshot = (cnt_reg == '0) && (scan_idx_reg == 2'd0);

  // Per-digit zero flags, leading-zero chain and active-high segment patterns.
  // lead_zero[i] means digits 3..i are all zero; any non-BCD nibble is non-zero
  // and therefore ends the blanking run.
  logic [3:0]      is_zero;
  logic [3:0]      lead_zero;
  logic [3:0][6:0] seg_pat;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
      assign is_zero[gi] = (shadow_reg[gi] == 4'd0);
      if (gi == 3) begin : g_top
        assign lead_zero[gi] = is_zero[gi];
      end else begin : g_lower
        assign lead_zero[gi] = is_zero[gi] & lead_zero[gi+1];
      end
      // Units digit is never blanked.
      if (gi == 0) begin : g_units
        assign seg_pat[gi] = decode(shadow_reg[gi]);
      end else begin : g_upper
        assign seg_pat[gi] = (lz_shadow_reg && lead_zero[gi]) ? 7'h00
                                                              : decode(shadow_reg[gi]);
      end
    end
  endgenerate

  // Scan counter and snapshot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg        <= '0;
      scan_idx_reg   <= 2'd0;
      shadow_reg     <= '0;
      dp_shadow_reg  <= 4'd0;
      lz_shadow_reg  <= 1'b0;
      frame_tick_reg <= 1'b0;
    end else begin
      if (cnt_reg == CNT_MAX) begin
        cnt_reg      <= '0;
        scan_idx_reg <= scan_idx_reg + 2'd1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      if (snapshot) begin
        shadow_reg    <= {Qdata3, Qdata2, Qdata1, Qdata0};
        dp_shadow_reg <= dp_mask;
        lz_shadow_reg <= lz_en;
      end
      frame_tick_reg <= snapshot;
    end
  end

  // Pin values for the current scan position. The snapshot edge always falls
  // in a BLANK cycle, so the shadow registers are settled before any DRIVE.
  always_comb begin
    slot_state = (cnt_reg < BLANK_END) ? SLOT_BLANK : SLOT_DRIVE;
    an_next    = AN_OFF;
    seg_next   = SEG_OFF;
    dp_next    = DP_OFF;
    case (slot_state)
      SLOT_DRIVE: begin
        an_next  = AN_OFF ^ (4'b0001 << scan_idx_reg);
        seg_next = COMMON_ANODE ? ~seg_pat[scan_idx_reg] : seg_pat[scan_idx_reg];
        dp_next  = COMMON_ANODE ? ~dp_shadow_reg[scan_idx_reg]
                                : dp_shadow_reg[scan_idx_reg];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_reg        <= AN_OFF;
      seg_reg       <= SEG_OFF;
      dp_reg        <= DP_OFF;
      digit_idx_reg <= 2'd0;
    end else begin
      an_reg        <= an_next;
      seg_reg       <= seg_next;
      dp_reg        <= dp_next;
      digit_idx_reg <= scan_idx_reg;
    end
  end

  assign an         = an_reg;
  assign seg        = seg_reg;
  assign dp         = dp_reg;
  assign digit_idx  = digit_idx_reg;
  assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_display_mux_7seg.sv
// -----------------------------------------------------------------------------
// tb_display_mux_7seg
//   Self-checking bench for display_mux_7seg (SCAN_DIV=8, BLANK_CYCLES=2,
//   COMMON_ANODE=1). A frame-level model predicts every pin on every cycle from
//   the number of edges since reset; directed literal checks pin that model.
// -----------------------------------------------------------------------------
module tb_display_mux_7seg;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] q [4];
  logic [3:0] dp_mask = 4'd0;
  logic       lz_en = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [1:0] digit_idx;
  logic       frame_tick;

  int checks = 0;
  int errors = 0;

  display_mux_7seg #(.SCAN_DIV(SD), .BLANK_CYCLES(BC), .COMMON_ANODE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .Qdata3(q[3]), .Qdata2(q[2]), .Qdata1(q[1]), .Qdata0(q[0]),
    .dp_mask(dp_mask), .lz_en(lz_en),
    .an(an), .seg(seg), .dp(dp), .digit_idx(digit_idx), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Active-high gfedcba table for nibble values 0..15.
  logic [6:0] seg_hi [16];
  initial begin
    seg_hi = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
               7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  end

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- Behavioural model ----------------
  // k counts edges since reset release. Output after edge k belongs to slot
  // (k/SD)%4 at position k%SD; a new snapshot is taken every FRAME edges.
  int         k = 0;
  bit         model_valid = 0;
  logic [3:0] snap_d [4];
  logic [3:0] snap_dp;
  logic       snap_lz;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp, exp_ft;
  logic [1:0] exp_idx;

  always @(posedge clk) begin
    int  slot, pos;
    bit  blank;
    model_valid = 1;
    if (rst) begin
      k = 0;
      exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_ft = 1'b0; exp_idx = 2'd0;
    end else begin
      if (k % FRAME == 0) begin
        for (int j = 0; j < 4; j++) snap_d[j] = q[j];
        snap_dp = dp_mask;
        snap_lz = lz_en;
      end
      slot    = (k / SD) % 4;
      pos     = k % SD;
      exp_ft  = (k % FRAME == 0);
      exp_idx = 2'(slot);
      if (pos < BC) begin
        exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
        exp_an = 4'hF & ~(4'b0001 << slot);
        blank  = snap_lz && (slot != 0);
        for (int j = slot; j < 4; j++) if (snap_d[j] != 4'd0) blank = 0;
        exp_seg = blank ? 7'h7F : ~seg_hi[snap_d[slot]];
        exp_dp  = ~snap_dp[slot];
      end
      k++;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("an", {4'd0, an}, {4'd0, exp_an});
      check("seg", {1'b0, seg}, {1'b0, exp_seg});
      check("dp", {7'd0, dp}, {7'd0, exp_dp});
      check("frame_tick", {7'd0, frame_tick}, {7'd0, exp_ft});
      check("digit_idx", {6'd0, digit_idx}, {6'd0, exp_idx});
    end
  end

  // ---------------- Directed + random stimulus ----------------
  task automatic wait_tick();
    bit seen = 0;
    for (int i = 0; i < 4 * FRAME && !seen; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_tick_timeout: got no pulse expected pulse within %0d cycles", 4 * FRAME);
    end
  endtask

  task automatic skip(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_q(input logic [3:0] d3, input logic [3:0] d2,
                       input logic [3:0] d1, input logic [3:0] d0);
    q[3] = d3; q[2] = d2; q[1] = d1; q[0] = d0;
  endtask

  task automatic lit(input string name, input logic [3:0] a, input logic [6:0] s);
    check({name, "_an"}, {4'd0, an}, {4'd0, a});
    check({name, "_seg"}, {1'b0, seg}, {1'b0, s});
    check({name, "_model_seg"}, {1'b0, exp_seg}, {1'b0, s});
    $display("step %s: an=%h seg=%h dp=%b idx=%0d", name, an, seg, dp, digit_idx);
  endtask

  initial begin
    set_q(4'd1, 4'd2, 4'd3, 4'd4);
    // 1. reset
    skip(3);
    check("rst_an", {4'd0, an}, 8'h0F);
    check("rst_seg", {1'b0, seg}, 8'h7F);
    check("rst_dp", {7'd0, dp}, 8'h01);
    check("rst_ft", {7'd0, frame_tick}, 8'h00);
    check("rst_idx", {6'd0, digit_idx}, 8'h00);
    rst = 1'b0;

    // 2. basic scan of 1,2,3,4
    wait_tick();
    check("t2_an_blank", {4'd0, an}, 8'h0F);
    skip(1);  lit("t2_b1", 4'hF, 7'h7F);
    skip(1);  lit("t2_d0", 4'hE, 7'h19);
    skip(8);  lit("t2_d1", 4'hD, 7'h30);
    skip(8);  lit("t2_d2", 4'hB, 7'h24);
    skip(8);  lit("t2_d3", 4'h7, 7'h79);
    skip(6);  check("t2_period", {7'd0, frame_tick}, 8'h01);

    // 3. leading-zero blanking
    set_q(4'd0, 4'd0, 4'd4, 4'd0); lz_en = 1'b1;
    wait_tick();
    skip(2);  lit("t3_d0", 4'hE, 7'h40);
    skip(8);  lit("t3_d1", 4'hD, 7'h19);
    skip(8);  lit("t3_d2", 4'hB, 7'h7F);
    skip(8);  lit("t3_d3", 4'h7, 7'h7F);
    set_q(4'd0, 4'd0, 4'd0, 4'd0);
    wait_tick();
    skip(2);  lit("t3z_d0", 4'hE, 7'h40);
    skip(8);  lit("t3z_d1", 4'hD, 7'h7F);

    // 4. anti-tear: change inputs mid-frame at cnt=3 of digit1
    wait_tick();
    skip(11);
    set_q(4'd9, 4'd8, 4'd7, 4'd6); lz_en = 1'b0;
    skip(7);  lit("t4_old_d2", 4'hB, 7'h7F);
    skip(8);  lit("t4_old_d3", 4'h7, 7'h7F);
    wait_tick();
    skip(26); lit("t4_new_d3", 4'h7, 7'h10);

    // 5. non-BCD nibble and decimal point
    set_q(4'd0, 4'd0, 4'd0, 4'hC); dp_mask = 4'b0001;
    wait_tick();
    skip(2);  lit("t5_d0", 4'hE, 7'h3F);
    check("t5_dp_d0", {7'd0, dp}, 8'h00);
    skip(8);  lit("t5_d1", 4'hD, 7'h40);
    check("t5_dp_d1", {7'd0, dp}, 8'h01);

    // random phase: inputs change at arbitrary times, occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < 4; j++)
          q[j] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        dp_mask = 4'($urandom_range(0, 15));
        lz_en   = 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    rst = 1'b0;
    $display("step random: %0d checks so far", checks);

    // 6. reset during digit2 DRIVE
    set_q(4'd5, 4'd6, 4'd7, 4'd8); lz_en = 1'b0; dp_mask = 4'd0;
    wait_tick();
    skip(18);
    rst = 1'b1;
    skip(1);  lit("t6_rst", 4'hF, 7'h7F);
    rst = 1'b0;
    skip(1);  check("t6_ft", {7'd0, frame_tick}, 8'h01);
    check("t6_an_blank", {4'd0, an}, 8'h0F);
    skip(2);  lit("t6_d0", 4'hE, 7'h00);

    skip(4);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
